// File: rtl/base_health_update_pkg.sv
// Shared definitions for the base hit-point update stage: default widths,
// starting hit points and the one-hot state encoding.
package base_health_update_pkg;

  localparam int HP_W_DEF    = 12;
  localparam int BASE_HP_DEF = 1000;
  localparam int RC_W_DEF    = 16;
  // Totals arriving from the damage summation stage are this wide.
  localparam int DMG_W       = 12;

  localparam logic [5:0] ST_IDLE    = 6'b00_0001;
  localparam logic [5:0] ST_REQUEST = 6'b00_0010;
  localparam logic [5:0] ST_WAIT    = 6'b00_0100;
  localparam logic [5:0] ST_APPLY   = 6'b00_1000;
  localparam logic [5:0] ST_ACK     = 6'b01_0000;
  localparam logic [5:0] ST_OVER    = 6'b10_0000;

  typedef enum logic [5:0] {
    S_IDLE    = ST_IDLE,
    S_REQUEST = ST_REQUEST,
    S_WAIT    = ST_WAIT,
    S_APPLY   = ST_APPLY,
    S_ACK     = ST_ACK,
    S_OVER    = ST_OVER
  } state_e;

endpackage

// File: rtl/base_health_update_sat_sub.sv
// Combinational saturating subtractor: y = a - b, floored at zero.
module sat_sub #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = (b >= a) ? '0 : a - b;
  end

endmodule

// File: rtl/base_health_update.sv
// Per-frame base hit-point update: requests a damage total from the summation
// stage, applies it to both bases with saturation, and reports the outcome.
module base_health_update
  import base_health_update_pkg::*;
#(
  parameter int HP_W    = HP_W_DEF,
  parameter int BASE_HP = BASE_HP_DEF,
  parameter int RC_W    = RC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            newGame,
  output logic            calcStart,
  input  logic            calcDone,
  output logic            calcAck,
  input  logic [HP_W-1:0] totalUnitDamage,
  input  logic [HP_W-1:0] totalEnemyDamage,
  output logic [HP_W-1:0] playerHP,
  output logic [HP_W-1:0] enemyHP,
  output logic [RC_W-1:0] roundCount,
  output logic            busy,
  output logic            gameOver,
  output logic            win,
  output logic            lose,
  output logic            tickMiss
);

  localparam logic [HP_W-1:0] HP_INIT = HP_W'(BASE_HP);

  state_e          state_q, state_d;
  logic [HP_W-1:0] player_hp_q, player_hp_d;
  logic [HP_W-1:0] enemy_hp_q, enemy_hp_d;
  logic [RC_W-1:0] round_q, round_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            over_q, over_d;
  logic            miss_q, miss_d;
  logic            pending_q, pending_d;

  logic [HP_W-1:0] enemy_next, player_next;
  logic            restart;
  logic            in_busy;

  sat_sub #(.W(HP_W)) u_enemy_sub (
    .a (enemy_hp_q),
    .b (totalUnitDamage),
    .y (enemy_next)
  );

  sat_sub #(.W(HP_W)) u_player_sub (
    .a (player_hp_q),
    .b (totalEnemyDamage),
    .y (player_next)
  );

  assign in_busy = (state_q == S_REQUEST) || (state_q == S_WAIT) ||
                   (state_q == S_APPLY)   || (state_q == S_ACK);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    player_hp_d = player_hp_q;
    enemy_hp_d  = enemy_hp_q;
    round_d     = round_q;
    win_d       = win_q;
    lose_d      = lose_q;
    over_d      = over_q;
    miss_d      = miss_q | (tick & in_busy);
    pending_d   = pending_q | (newGame & in_busy);
    restart     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (newGame)   restart = 1'b1;
        else if (tick) state_d = S_REQUEST;
      end
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: begin
        if (calcDone) state_d = S_APPLY;
      end
      S_APPLY: begin
        enemy_hp_d  = enemy_next;
        player_hp_d = player_next;
        if (round_q != '1) round_d = round_q + RC_W'(1);
        win_d   = (enemy_next == '0) && (player_next != '0);
        lose_d  = (player_next == '0);
        over_d  = (enemy_next == '0) || (player_next == '0);
        state_d = S_ACK;
      end
      S_ACK: begin
        // A restart requested mid-handshake wins over the game-over exit.
        if (!calcDone) begin
          if (pending_q || newGame) restart = 1'b1;
          else if (over_q)          state_d = S_OVER;
          else                      state_d = S_IDLE;
        end
      end
      S_OVER: begin
        if (newGame) restart = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d     = S_IDLE;
      player_hp_d = HP_INIT;
      enemy_hp_d  = HP_INIT;
      round_d     = '0;
      win_d       = 1'b0;
      lose_d      = 1'b0;
      over_d      = 1'b0;
      miss_d      = 1'b0;
      pending_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      player_hp_q <= HP_INIT;
      enemy_hp_q  <= HP_INIT;
      round_q     <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      over_q      <= 1'b0;
      miss_q      <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      player_hp_q <= player_hp_d;
      enemy_hp_q  <= enemy_hp_d;
      round_q     <= round_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      over_q      <= over_d;
      miss_q      <= miss_d;
      pending_q   <= pending_d;
    end
  end

  assign calcStart  = (state_q == S_REQUEST);
  assign calcAck    = (state_q == S_ACK);
  assign busy       = in_busy;
  assign playerHP   = player_hp_q;
  assign enemyHP    = enemy_hp_q;
  assign roundCount = round_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign gameOver   = over_q;
  assign tickMiss   = miss_q;

endmodule

// File: doc/base_health_update.md
# base_health_update

Downstream consumer of the per-frame damage summation stage. On each game frame tick, it requests a damage total and waits for completion. It then applies the unit and enemy totals to the two base hit-point registers with saturating subtraction and acknowledges the summation stage. It reports win/lose/game-over to the display and game-control logic.

## Interface

- `HP_W`, 12, width of hit-point and damage totals
- `BASE_HP`, 1000, hit points loaded into both bases on reset and on `newGame`
- `RC_W`, 16, width of round counter
- `clk` in 1: system clock
- `rst` in 1: one clock; reset is synchronous and active-low
- `tick` in 1: one-cycle frame strobe from game timing
- `newGame` in 1: one-cycle request to restart the battle
- `calcStart` out 1: Start to damage summation stage
- `calcDone` in 1: Done from damage summation stage
- `calcAck` out 1: Ack to damage summation stage
- `totalUnitDamage` in HP_W: damage dealt by player units to enemy base; valid while `calcDone`=1
- `totalEnemyDamage` in HP_W: damage dealt by enemies to player base; valid while `calcDone`=1
- `playerHP` out HP_W: player base hit points
- `enemyHP` out HP_W: enemy base hit points
- `roundCount` out RC_W: completed damage rounds since reset/newGame
- `busy` out 1: high in REQUEST, WAIT, APPLY, ACK
- `gameOver` out 1: either base at 0
- `win` out 1: enemyHP==0 and playerHP!=0
- `lose` out 1: playerHP==0 (a draw counts as lose)
- `tickMiss` out 1: sticky, set when a tick arrives while busy

## Operation

- FSM, one-hot: IDLE, REQUEST, WAIT, APPLY, ACK, OVER.
- **IDLE:** on `tick`, go to REQUEST.
- **REQUEST:** `calcStart`=1 for exactly this one cycle, then go to WAIT.
- **WAIT:** hold until `calcDone`=1, then go to APPLY.
  - No timeout.
- **APPLY:** one cycle.
  - `enemyHP` <= sat(`enemyHP` − `totalUnitDamage`).
  - `playerHP` <= sat(`playerHP` − `totalEnemyDamage`).
  - `roundCount` increments, saturating at all-ones.
  - Then go to ACK.
- **ACK:** `calcAck`=1 while in ACK; leave when `calcDone`=0.
  - If either HP is 0, go to OVER; else go to IDLE.
- **OVER:** all ticks ignored (no `tickMiss`); wait for `newGame`.
- **Saturating subtract:** if damage >= hp, the result is 0; otherwise hp − damage. Full HP_W width, no wrap.
- **win/lose/gameOver:** registered, updated in the same cycle the HP registers update in APPLY.
- **newGame:**
  - In IDLE or OVER: next cycle both HP = BASE_HP, `roundCount`=0, `tickMiss`=0, flags cleared, state IDLE.
  - In REQUEST/WAIT/APPLY/ACK: latched as pending. The handshake completes normally, then the pending restart is applied on entry to IDLE/OVER, taking priority over going to OVER. This never strands the summation stage with Done held.
- **tick:** while busy, the tick is dropped and `tickMiss` is set. `tick` coincident with `newGame` in IDLE: `newGame` wins and the tick is dropped without setting `tickMiss`.
- **rst low:** state IDLE, `playerHP`=`enemyHP`=BASE_HP, `roundCount`=0, `calcStart`=`calcAck`=0, `win`=`lose`=`gameOver`=`tickMiss`=0, pending restart cleared. Reset mid-handshake relies on the summation stage sharing the same reset.

## Timing

- Tick at cycle T: `calcStart` high at T+1, WAIT from T+2.
- `calcDone` first high at cycle D: HP updated, visible at D+2; `calcAck` high from D+2.
- With the summation stage's one-cycle Ack response, `calcDone` low at D+3 and IDLE at D+4.
- Minimum tick-to-IDLE with an immediate Done: 6 cycles.
- `busy` is a decode of state, with no extra latency.

## Structure

- **Shared package:**
  - State localparams (one-hot, 6 bits).
  - HP_W/BASE_HP/RC_W defaults.
  - Damage-total width, equal to the summation stage's 12-bit totals.
- **Sub-module `sat_sub`:**
  - Parameter W; combinational saturating subtractor, `a`−`b` floored at 0.
  - Instantiated twice, once per base.
- **FSM and registers** live in `base_health_update`.

## Test plan

- Reset, then tick with Done returning damages 100/40 → `enemyHP`=900, `playerHP`=960, `roundCount`=1, one-cycle `calcStart`, `calcAck` held until Done falls, back to IDLE.
- `enemyHP`=50, unit damage 200, enemy damage 0 → `enemyHP`=0 (no wrap), `win`=1, `gameOver`=1, state OVER; further ticks cause no `calcStart`.
- Both HP=10, damages 10/10 → both 0, `lose`=1, `win`=0.
- Tick pulsed during WAIT → ignored, `tickMiss`=1, exactly one `calcStart` issued.
- `newGame` asserted during WAIT, Done at +3 → handshake completes with HP applied, then HP=1000/1000, `roundCount`=0 in IDLE.
- `rst` low for 1 cycle mid-ACK → all outputs at reset values next cycle, `calcAck`=0.
